// File: rtl/aimc_lib.sv
// Shared AIMC definitions: command encoding, utilization categories and the
// clocking/averaging constants used by the utilization monitor.
package aimc_lib;

    localparam GLOBAL_CLK = "CK_DIV1";
    localparam int AVG_SHIFT = 4;

    localparam int CAT_W = 3;
    localparam logic [CAT_W-1:0] CAT_WRITE   = 3'd7;
    localparam logic [CAT_W-1:0] CAT_READ    = 3'd6;
    localparam logic [CAT_W-1:0] CAT_COMPUTE = 3'd5;
    localparam logic [CAT_W-1:0] CAT_OPEN    = 3'd4;
    localparam logic [CAT_W-1:0] CAT_REFRESH = 3'd3;
    localparam logic [CAT_W-1:0] CAT_OTHER   = 3'd2;

    typedef enum logic [4:0] {
        NOP1, WOM, WDM, WRGB, WRBIAS, WRBK,
        RD, RDMAC, RDAF,
        MACSB, MAC4B, MACAB, AF, EWMUL, RDCP, WRCP,
        ACT, ACT4, ACT16, ACTAF4, ACTAF16, NDME, NDMX, PREPB, PREAB,
        REFPB, REFAB, MRS_TEMP,
        MRS, SRE, SRX, PDE
    } cmd_t;

    typedef struct packed {
        logic             en;
        logic [CAT_W-1:0] cat;
    } cat_sel_t;

    // NOP1 is idle time, so it is the only command that does not count.
    function automatic cat_sel_t cmd2cat(input cmd_t c);
        cat_sel_t r;
        r.en  = 1'b1;
        r.cat = CAT_OTHER;
        case (c)
            WOM, WDM, WRGB, WRBIAS, WRBK:                        r.cat = CAT_WRITE;
            RD, RDMAC, RDAF:                                     r.cat = CAT_READ;
            MACSB, MAC4B, MACAB, AF, EWMUL, RDCP, WRCP:          r.cat = CAT_COMPUTE;
            ACT, ACT4, ACT16, ACTAF4, ACTAF16, NDME, NDMX,
            PREPB, PREAB:                                        r.cat = CAT_OPEN;
            REFPB, REFAB, MRS_TEMP:                              r.cat = CAT_REFRESH;
            NOP1:                                                r.en  = 1'b0;
            default:                                             r.cat = CAT_OTHER;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/util_mon_mc_if.sv
// Command inputs and utilization report bundle of the utilization monitor.
interface util_mon_mc_if
    import aimc_lib::*;
#(
    parameter int NUM_CH  = 1,
    parameter int NUM_CAT = 8,
    parameter int OUT_W   = 7
);
    cmd_t [NUM_CH-1:0]             cmd;
    logic [NUM_CH-1:0]             cmd_valid;
    logic                          mode;
    logic                          mon_upd;
    logic                          peak_clr;
    logic [NUM_CAT-1:0][OUT_W-1:0] util;
    logic [NUM_CAT-1:0][OUT_W-1:0] util_peak;
    logic                          util_vld;
    logic [NUM_CAT-1:0]            ovf;

    modport master (
        output cmd, cmd_valid, mode, mon_upd, peak_clr,
        input  util, util_peak, util_vld, ovf
    );

    modport slave (
        input  cmd, cmd_valid, mode, mon_upd, peak_clr,
        output util, util_peak, util_vld, ovf
    );
endinterface

// File: rtl/util_cat_cnt.sv
// One saturating utilization counter; nxt is the saturated value including
// this cycle's increment, which is also what a closing window reports.
module util_cat_cnt #(
    parameter int CNT_W = 32,
    parameter int INC_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [INC_W-1:0] inc,
    output logic [CNT_W-1:0] nxt,
    output logic             sat
);
    localparam int SUM_W = ((CNT_W > INC_W) ? CNT_W : INC_W) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt;
    logic [SUM_W-1:0] sum;

    assign sum = SUM_W'(cnt) + SUM_W'(inc);
    assign sat = sum > SUM_W'(CNT_MAX);
    assign nxt = sat ? CNT_MAX : sum[CNT_W-1:0];

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            cnt <= '0;
        end else begin
            cnt <= nxt;
        end
    end
endmodule

// File: rtl/util_mon_mc.sv
// Per-category command utilization monitor: counts weighted commands over a
// window (timer or external close) and reports scaled snapshots and peaks.
module util_mon_mc
    import aimc_lib::*;
#(
    parameter int NUM_CH   = 1,
    parameter int NUM_CAT  = 8,
    parameter int CNT_W    = 32,
    parameter int OUT_W    = 7,
    parameter int AVG_SH   = AVG_SHIFT,
    parameter int WIN_LOG2 = AVG_SHIFT,
    parameter int CNT_INC  = (GLOBAL_CLK == "CK_DIV1") ? 100 : 50
) (
    input logic          clk,
    input logic          rst_n,
    util_mon_mc_if.slave bus
);
    localparam int CH_W  = $clog2(NUM_CH + 1);
    localparam int INC_W = $clog2(CNT_INC * NUM_CH + 1);
    localparam logic [CNT_W-1:0] OUT_MAX = CNT_W'((1 << OUT_W) - 1);

    cat_sel_t                      dec [NUM_CH];
    logic [NUM_CAT-1:0][OUT_W-1:0] snap;
    logic [NUM_CAT-1:0]            sat;
    logic [WIN_LOG2-1:0]           timer;
    logic                          mode_q;
    logic                          started;
    logic                          mode_chg;
    logic                          wclose;
    logic                          snap_en;
    logic [NUM_CAT-1:0][OUT_W-1:0] util_r;
    logic [NUM_CAT-1:0][OUT_W-1:0] peak_r;
    logic                          util_vld_r;
    logic [NUM_CAT-1:0]            ovf_r;

    always_comb begin
        for (int ch = 0; ch < NUM_CH; ch++) begin
            dec[ch] = cmd2cat(bus.cmd[ch]);
        end
    end

    // The first cycle after reset compares against a cleared mode_q, so it
    // must not be mistaken for a mode switch.
    assign mode_chg = started && (bus.mode != mode_q);
    assign wclose   = bus.mon_upd || (bus.mode && (timer == '1));
    assign snap_en  = wclose && !mode_chg;

    for (genvar c = 0; c < NUM_CAT; c++) begin : g_cat
        if (c < CAT_OTHER) begin : g_rsvd
            assign snap[c] = '0;
            assign sat[c]  = 1'b0;
        end else begin : g_live
            logic [CH_W-1:0]  hits;
            logic [INC_W-1:0] inc;
            logic [CNT_W-1:0] nxt;
            logic [CNT_W-1:0] shifted;

            always_comb begin
                hits = '0;
                for (int ch = 0; ch < NUM_CH; ch++) begin
                    if (bus.cmd_valid[ch] && dec[ch].en && (dec[ch].cat == CAT_W'(c))) begin
                        hits = hits + CH_W'(1);
                    end
                end
            end

            assign inc = INC_W'(hits * CNT_INC);

            util_cat_cnt #(
                .CNT_W (CNT_W),
                .INC_W (INC_W)
            ) u_cnt (
                .clk   (clk),
                .rst_n (rst_n),
                .clr   (wclose || mode_chg),
                .inc   (inc),
                .nxt   (nxt),
                .sat   (sat[c])
            );

            assign shifted = nxt >> AVG_SH;
            assign snap[c] = (shifted > OUT_MAX) ? OUT_W'(OUT_MAX) : OUT_W'(shifted);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            timer      <= '0;
            mode_q     <= 1'b0;
            started    <= 1'b0;
            util_r     <= '0;
            peak_r     <= '0;
            util_vld_r <= 1'b0;
            ovf_r      <= '0;
        end else begin
            started    <= 1'b1;
            mode_q     <= bus.mode;
            timer      <= (mode_chg || !bus.mode || wclose) ? '0 : timer + WIN_LOG2'(1);
            util_vld_r <= snap_en;
            if (snap_en) begin
                util_r <= snap;
            end
            // A clear coinciding with a snapshot restarts the peak at the new value.
            for (int c = 0; c < NUM_CAT; c++) begin
                if (snap_en) begin
                    peak_r[c] <= (bus.peak_clr || (snap[c] > peak_r[c])) ? snap[c] : peak_r[c];
                end else if (bus.peak_clr) begin
                    peak_r[c] <= '0;
                end
            end
            ovf_r <= bus.peak_clr ? '0 : (ovf_r | sat);
        end
    end

    assign bus.util      = util_r;
    assign bus.util_peak = peak_r;
    assign bus.util_vld  = util_vld_r;
    assign bus.ovf       = ovf_r;
endmodule

// File: tb/tb_util_mon_mc.sv
// Testbench for util_mon_mc: directed scenarios plus random traffic, all
// outputs compared every cycle against an integer reference model.
module tb_util_mon_mc;
    import aimc_lib::*;

    localparam int INC  = 100;
    localparam int SH   = 4;
    localparam int WIN  = 16;
    localparam int OMAX = 127;

    logic clk = 1'b0;
    logic rst_n;
    int   n_total = 0;
    int   n_pass  = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    util_mon_mc_if #(.NUM_CH(2), .NUM_CAT(8), .OUT_W(7)) bus ();
    util_mon_mc_if #(.NUM_CH(1), .NUM_CAT(8), .OUT_W(7)) bus8 ();

    util_mon_mc #(.NUM_CH(2), .AVG_SH(4), .WIN_LOG2(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    util_mon_mc #(.NUM_CH(1), .CNT_W(8), .AVG_SH(4), .WIN_LOG2(4)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    function automatic int cat_of(input cmd_t c);
        case (c)
            WOM, WDM, WRGB, WRBIAS, WRBK:                                    return 7;
            RD, RDMAC, RDAF:                                                 return 6;
            MACSB, MAC4B, MACAB, AF, EWMUL, RDCP, WRCP:                      return 5;
            ACT, ACT4, ACT16, ACTAF4, ACTAF16, NDME, NDMX, PREPB, PREAB:     return 4;
            REFPB, REFAB, MRS_TEMP:                                          return 3;
            NOP1:                                                            return -1;
            default:                                                         return 2;
        endcase
    endfunction

    // Reference model, index 0 = 32-bit two-channel instance, 1 = 8-bit single channel.
    longint   m_cnt [2][8];
    longint   m_tot;
    longint   cmax;
    int       m_add [8];
    int       m_timer [2];
    bit       m_mode_q [2];
    bit       m_started [2];
    bit       m_vld [2];
    int       m_util [2][8];
    int       m_peak [2][8];
    bit [7:0] m_ovf [2];
    bit       m_chg, m_wc, i_mode, i_upd, i_pclr;
    int       m_new, c_idx;

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                m_timer[i]   = 0;
                m_mode_q[i]  = 1'b0;
                m_started[i] = 1'b0;
                m_vld[i]     = 1'b0;
                m_ovf[i]     = '0;
                for (int c = 0; c < 8; c++) begin
                    m_cnt[i][c]  = 0;
                    m_util[i][c] = 0;
                    m_peak[i][c] = 0;
                end
            end else begin
                for (int c = 0; c < 8; c++) m_add[c] = 0;
                if (i == 0) begin
                    i_mode = bus.mode;
                    i_upd  = bus.mon_upd;
                    i_pclr = bus.peak_clr;
                    cmax   = 64'd4294967295;
                    for (int ch = 0; ch < 2; ch++) begin
                        if (bus.cmd_valid[ch]) begin
                            c_idx = cat_of(bus.cmd[ch]);
                            if (c_idx >= 2) m_add[c_idx] += INC;
                        end
                    end
                end else begin
                    i_mode = bus8.mode;
                    i_upd  = bus8.mon_upd;
                    i_pclr = bus8.peak_clr;
                    cmax   = 64'd255;
                    if (bus8.cmd_valid[0]) begin
                        c_idx = cat_of(bus8.cmd[0]);
                        if (c_idx >= 2) m_add[c_idx] += INC;
                    end
                end
                m_chg = m_started[i] && (i_mode != m_mode_q[i]);
                m_wc  = i_upd || (i_mode && (m_timer[i] == WIN - 1));
                for (int c = 2; c < 8; c++) begin
                    m_tot = m_cnt[i][c] + m_add[c];
                    if (m_tot > cmax) begin
                        m_tot        = cmax;
                        m_ovf[i][c]  = 1'b1;
                    end
                    m_cnt[i][c] = (m_chg || m_wc) ? 0 : m_tot;
                    if (m_wc && !m_chg) begin
                        m_new = int'(m_tot / WIN);
                        if (m_new > OMAX) m_new = OMAX;
                        m_util[i][c] = m_new;
                        if (i_pclr || (m_new > m_peak[i][c])) m_peak[i][c] = m_new;
                    end else if (i_pclr) begin
                        m_peak[i][c] = 0;
                    end
                end
                if (i_pclr) m_ovf[i] = '0;
                m_vld[i]     = m_wc && !m_chg;
                m_timer[i]   = (m_chg || !i_mode || m_wc) ? 0 : m_timer[i] + 1;
                m_mode_q[i]  = i_mode;
                m_started[i] = 1'b1;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        check($sformatf("%s vld", tag), 64'(bus.util_vld), 64'(m_vld[0]));
        check($sformatf("%s vld8", tag), 64'(bus8.util_vld), 64'(m_vld[1]));
        for (int c = 0; c < 8; c++) begin
            check($sformatf("%s util[%0d]", tag, c), 64'(bus.util[c]), 64'(m_util[0][c]));
            check($sformatf("%s peak[%0d]", tag, c), 64'(bus.util_peak[c]), 64'(m_peak[0][c]));
            check($sformatf("%s ovf[%0d]", tag, c), 64'(bus.ovf[c]), 64'(m_ovf[0][c]));
            check($sformatf("%s util8[%0d]", tag, c), 64'(bus8.util[c]), 64'(m_util[1][c]));
            check($sformatf("%s peak8[%0d]", tag, c), 64'(bus8.util_peak[c]), 64'(m_peak[1][c]));
            check($sformatf("%s ovf8[%0d]", tag, c), 64'(bus8.ovf[c]), 64'(m_ovf[1][c]));
        end
    endtask

    task automatic applyStimulus(input string tag, input cmd_t c0, input bit v0,
                                 input cmd_t c1, input bit v1, input bit upd, input bit pclr);
        bus.cmd[0]       = c0;
        bus.cmd_valid[0] = v0;
        bus.cmd[1]       = c1;
        bus.cmd_valid[1] = v1;
        bus.mon_upd      = upd;
        bus.peak_clr     = pclr;
        @(posedge clk);
        #1;
        checkOutput(tag);
    endtask

    initial begin
        rst_n             = 1'b0;
        bus.mode          = 1'b1;
        bus8.mode         = 1'b0;
        bus8.cmd[0]       = NOP1;
        bus8.cmd_valid[0] = 1'b0;
        bus8.mon_upd      = 1'b0;
        bus8.peak_clr     = 1'b0;
        applyStimulus("rst", NOP1, 1'b0, NOP1, 1'b0, 1'b0, 1'b0);
        applyStimulus("rst", NOP1, 1'b0, NOP1, 1'b0, 1'b0, 1'b0);
        check("rst util", 64'(bus.util), 64'd0);
        check("rst peak", 64'(bus.util_peak), 64'd0);
        check("rst vld", 64'(bus.util_vld), 64'd0);
        check("rst ovf", 64'(bus.ovf), 64'd0);
        check("rst ovf8", 64'(bus8.ovf), 64'd0);
        rst_n = 1'b1;

        // Window 1: WRBK every other cycle; the 8-bit instance saturates on ACT.
        for (int k = 0; k < 16; k++) begin
            bus8.cmd[0]       = ACT;
            bus8.cmd_valid[0] = (k < 3);
            applyStimulus("win1", WRBK, (k % 2 == 0), NOP1, 1'b0, 1'b0, 1'b0);
            if (k == 1) check("ovf8 before sat", 64'(bus8.ovf[4]), 64'd0);
            if (k == 2) check("ovf8 at sat", 64'(bus8.ovf[4]), 64'd1);
            if (k == 14) check("win1 vld early", 64'(bus.util_vld), 64'd0);
        end
        check("win1 vld", 64'(bus.util_vld), 64'd1);
        check("win1 util7", 64'(bus.util[7]), 64'd50);
        check("win1 util6", 64'(bus.util[6]), 64'd0);
        check("ovf8 sticky", 64'(bus8.ovf[4]), 64'd1);

        // Window 2: both channels read every cycle, the result clamps.
        for (int k = 0; k < 16; k++) begin
            bus8.cmd_valid[0] = 1'b0;
            bus8.mon_upd      = (k == 0);
            bus8.peak_clr     = (k == 4);
            applyStimulus("win2", RD, 1'b1, RD, 1'b1, 1'b0, 1'b0);
            if (k == 0) begin
                check("win2 vld pulse", 64'(bus.util_vld), 64'd0);
                check("util8 held", 64'(bus8.util[4]), 64'd15);
            end
            if (k == 4) check("ovf8 cleared", 64'(bus8.ovf[4]), 64'd0);
        end
        bus8.mon_upd  = 1'b0;
        bus8.peak_clr = 1'b0;
        check("win2 util6", 64'(bus.util[6]), 64'd127);
        check("win2 util7", 64'(bus.util[7]), 64'd0);
        check("win2 peak7", 64'(bus.util_peak[7]), 64'd50);

        // Windows 3..5: peak tracking with clears off and on a snapshot.
        for (int k = 0; k < 16; k++) begin
            applyStimulus("win3", WRBK, (k < 7), NOP1, 1'b0, 1'b0, (k == 0));
            if (k == 0) check("peak cleared", 64'(bus.util_peak), 64'd0);
        end
        check("win3 util7", 64'(bus.util[7]), 64'd43);
        for (int k = 0; k < 16; k++) applyStimulus("win4", WRBK, (k < 3), NOP1, 1'b0, 1'b0, 1'b0);
        check("win4 util7", 64'(bus.util[7]), 64'd18);
        check("win4 peak7", 64'(bus.util_peak[7]), 64'd43);
        for (int k = 0; k < 16; k++) applyStimulus("win5", WRBK, (k < 2), NOP1, 1'b0, 1'b0, (k == 15));
        check("win5 util7", 64'(bus.util[7]), 64'd12);
        check("win5 peak7", 64'(bus.util_peak[7]), 64'd12);
        check("win5 peak6", 64'(bus.util_peak[6]), 64'd0);

        // Mode switch mid-window discards the window, then mon_upd windows.
        for (int k = 0; k < 5; k++) applyStimulus("pre-sw", WRBK, 1'b1, NOP1, 1'b0, 1'b0, 1'b0);
        bus.mode = 1'b0;
        applyStimulus("mode sw", NOP1, 1'b0, NOP1, 1'b0, 1'b1, 1'b0);
        check("mode sw no vld", 64'(bus.util_vld), 64'd0);
        check("mode sw util7", 64'(bus.util[7]), 64'd12);
        for (int k = 0; k < 3; k++) applyStimulus("refab", REFAB, 1'b1, NOP1, 1'b0, 1'b0, 1'b0);
        applyStimulus("refab upd", REFAB, 1'b1, NOP1, 1'b0, 1'b1, 1'b0);
        check("upd vld", 64'(bus.util_vld), 64'd1);
        check("upd util3", 64'(bus.util[3]), 64'd25);
        check("upd util7", 64'(bus.util[7]), 64'd0);
        applyStimulus("upd2", NOP1, 1'b0, NOP1, 1'b0, 1'b1, 1'b0);
        check("upd2 vld", 64'(bus.util_vld), 64'd1);
        check("upd2 util3", 64'(bus.util[3]), 64'd0);
        applyStimulus("upd3", NOP1, 1'b0, REFAB, 1'b1, 1'b1, 1'b0);
        check("upd3 vld", 64'(bus.util_vld), 64'd1);
        check("upd3 util3", 64'(bus.util[3]), 64'd6);
        for (int k = 0; k < 20; k++) begin
            applyStimulus("mode0 idle", NOP1, 1'b0, NOP1, 1'b0, 1'b0, 1'b0);
            check("mode0 no vld", 64'(bus.util_vld), 64'd0);
        end
        check("mode0 util3 stable", 64'(bus.util[3]), 64'd6);

        // Mid-window reset, then NOP1-only traffic in timer mode.
        bus.mode = 1'b1;
        for (int k = 0; k < 6; k++) applyStimulus("pre-rst", WRBK, 1'b1, RD, 1'b1, 1'b0, 1'b0);
        rst_n = 1'b0;
        applyStimulus("mid rst", WRBK, 1'b1, RD, 1'b1, 1'b0, 1'b0);
        rst_n = 1'b1;
        for (int k = 0; k < 17; k++) begin
            applyStimulus("nop1", NOP1, 1'b1, NOP1, 1'b1, 1'b0, 1'b0);
            check("nop1 vld", 64'(bus.util_vld), 64'(k == 15));
            check("nop1 util", 64'(bus.util), 64'd0);
            check("nop1 peak", 64'(bus.util_peak), 64'd0);
            check("nop1 ovf", 64'(bus.ovf), 64'd0);
        end

        // Random traffic on both instances.
        for (int n = 0; n < 600; n++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            if ($urandom_range(0, 39) == 0) bus.mode = ~bus.mode;
            if ($urandom_range(0, 29) == 0) bus8.mode = ~bus8.mode;
            bus8.cmd[0]       = cmd_t'(5'($urandom_range(0, 31)));
            bus8.cmd_valid[0] = 1'($urandom_range(0, 1));
            bus8.mon_upd      = ($urandom_range(0, 9) == 0);
            bus8.peak_clr     = ($urandom_range(0, 19) == 0);
            applyStimulus("rand",
                          cmd_t'(5'($urandom_range(0, 31))), ($urandom_range(0, 3) != 0),
                          cmd_t'(5'($urandom_range(0, 31))), ($urandom_range(0, 3) != 0),
                          ($urandom_range(0, 11) == 0), ($urandom_range(0, 24) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
